// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 shift-add multiply sequencer for mul/mult/multu.
// Operates on magnitudes, then negates the 2*WIDTH product when operand signs differ.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       dest_in,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       dest_out
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [4:0]        tag_q, tag_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic [4:0]        dest_q, dest_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_s;
  logic [PW-1:0]     prod_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = ~v + ONE_W;
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign accept_s = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign stall    = busy_q | accept_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign dest_out  = dest_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dest_d   = dest_q;
    prod_s   = neg_q ? (~acc_q + ONE_P) : acc_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mcand_d  = {{WIDTH{1'b0}}, magnitude(a, signed_op)};
            mplier_d = magnitude(b, signed_op);
            neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            tag_d    = dest_in;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_RUN: begin
          // multiplicand walks left and multiplier walks right, so bit 0 is always the current bit
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + ONE_C;
          if (cnt_q == LAST_IT) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FIX: begin
          res_lo_d = prod_s[WIDTH-1:0];
          res_hi_d = prod_s[PW-1:WIDTH];
          dest_d   = tag_q;
          state_d  = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) | (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      tag_q    <= 5'd0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dest_q   <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      tag_q    <= tag_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected products queued at launch, checked on done.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  dest_in;
  logic        abort;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [4:0]  dest_out;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic [68:0] sb[$];
  logic [63:0] prior;

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .dest_in(dest_in), .abort(abort),
    .busy(busy), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .dest_out(dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (s) return 64'(sx * sy);
    else   return ux * uy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Drive a request through its accept edge; optionally queue the expected result.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [4:0] d, input bit push, input bit chk_stall);
    logic [63:0] p;
    start = 1'b1; a = x; b = y; signed_op = s; dest_in = d;
    #1;
    if (chk_stall) check("stall_accept", 64'(stall), 64'd1);
    p = ref_mul(x, y, s);
    if (push) sb.push_back({d, p});
    tick();
    edge_cnt = 1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (!done && edge_cnt < 100) tick();
    check(tag, 64'(edge_cnt), 64'd34);
  endtask

  // Pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexp_done", 64'(done), 64'd0);
      end else begin
        logic [68:0] e;
        e = sb.pop_front();
        check("result_lo", 64'(result_lo), 64'(e[31:0]));
        check("result_hi", 64'(result_hi), 64'(e[63:32]));
        check("dest_out",  64'(dest_out),  64'(e[68:64]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;
    dest_in = 5'd0; abort = 1'b0;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_dest", 64'(dest_out), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic signed multiply, latency and one-cycle done
    start_op(32'd2, 32'd3, 1'b1, 5'd8, 1'b1, 1'b1);
    check("run_busy", 64'(busy), 64'd1);
    check("run_stall", 64'(stall), 64'd1);
    wait_done("lat_basic");
    tick();
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    start_op(32'hFFFF_FFFE, 32'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    wait_done("lat_neg");
    tick();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd2, 1'b1, 1'b0);
    wait_done("lat_uns");
    tick();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 1'b0);
    wait_done("lat_sgn");
    tick();

    // start during RUN is ignored; start held in DONE chains with no bubble
    start_op(32'd100, 32'd200, 1'b0, 5'd9, 1'b1, 1'b0);
    repeat (4) tick();
    start = 1'b1; a = 32'd7; b = 32'd7; dest_in = 5'd30;
    tick();
    start = 1'b0;
    wait_done("lat_ignore");
    start_op(32'd4, 32'd5, 1'b0, 5'd4, 1'b1, 1'b0);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done", 64'(done), 64'd0);
    wait_done("lat_b2b");
    prior = ref_mul(32'd4, 32'd5, 1'b0);
    tick();

    // abort mid-run: no done, previous result retained
    start_op(32'd11, 32'd13, 1'b0, 5'd5, 1'b0, 1'b0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check("abort_keep_lo", 64'(result_lo), 64'(prior[31:0]));

    start = 1'b1; abort = 1'b1; a = 32'd9; b = 32'd9; dest_in = 5'd6;
    #1;
    check("abort_start_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    repeat (40) tick();

    // reset while in FIX
    start_op(32'd3, 32'd3, 1'b0, 5'd7, 1'b0, 1'b0);
    repeat (32) tick();
    check("fix_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("fixrst_busy", 64'(busy), 64'd0);
    check("fixrst_lo", 64'(result_lo), 64'd0);
    check("fixrst_hi", 64'(result_hi), 64'd0);
    check("fixrst_dest", 64'(dest_out), 64'd0);
    repeat (5) tick();

    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd31, 1'b1, 1'b0);
    wait_done("lat_minneg");
    tick();
    tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
